mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Drives the select lines and active-low enable of the 16:1 CM150-class selector, and reads its
//  single-bit output back. Sweeps channels 0..15, then assembles the sampled bits into a 16-bit frame.
//  Sits directly upstream of the selector on the select and enable lines, and directly downstream of it
//  on the data line. Publishes each frame on a valid/ready port to the next consumer.
// PARAMETERS
//  NCH        16  channels per frame; must be a power of two, at most 16
//  SELW       4   select width, equal to log2(NCH)
//  SETTLE_CYC 2   cycles the enable is held low before sampling (1..15)
//  INVERT     0   1: store ~mux_in instead of mux_in
// PORTS
//  clk          in   1     single clock; all logic on the rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  start        in   1     one-cycle pulse; begins a scan when the block is IDLE
//  cont         in   1     1: start the next frame automatically once the current one is published
//  abort        in   1     pulse; drops the scan in progress
//  ch_mask      in   NCH   1 = channel enabled; masked channels are skipped and their bit is stored as 0
//  mux_in       in   1     selector output (v)
//  sel          out  SELW  selector address (q=bit0 .. t=bit3)
//  en_n         out  1     selector enable (u); 1 = forces the selector output high
//  busy         out  1     high in any state other than IDLE
//  frame_data   out  NCH   completed frame; bit k holds channel k
//  frame_valid  out  1     frame_data valid; stays high until the consumer accepts it
//  frame_ready  in   1     consumer accepts the frame (transfer happens when valid & ready)
// BEHAVIOUR
//  Reset values: sel=0, en_n=1, busy=0, frame_data=0, frame_valid=0, FSM=IDLE, channel counter=0.
//  FSM states: IDLE, SETUP, SETTLE, SAMPLE, PUBLISH.
//   IDLE: start=1 -> clear the shadow register, ch=0 -> SETUP. start is ignored in every other state.
//   SETUP (1 cycle): sel<=ch, en_n=1.
//     If ch_mask[ch]=0: store shadow[ch]=0, then go to SAMPLE's "next channel" step with no settle.
//     Otherwise -> SETTLE.
//   SETTLE: en_n=0 for SETTLE_CYC cycles. On the last cycle, shadow[ch] <= mux_in^INVERT -> SAMPLE.
//   SAMPLE (1 cycle): en_n=1. If ch==NCH-1 -> PUBLISH; else ch<=ch+1 -> SETUP.
//   PUBLISH: if frame_valid=0, or valid&ready in this cycle: frame_data<=shadow, frame_valid<=1.
//     Then go to SETUP with ch=0 if cont=1, else to IDLE. Otherwise stay in PUBLISH
//     (backpressure, no frame is ever dropped).
//  Cost per enabled channel: 1+SETTLE_CYC+1 cycles; per masked channel: 2 cycles.
//  Full frame (all channels enabled, default params): 64 cycles from the start edge to frame_valid.
//  frame_valid clears on valid&ready unless a new frame loads in the same cycle (then it stays 1).
//  sel changes only in SETUP, while en_n=1. The selector is never enabled while its address changes.
//  abort (any state): -> IDLE, en_n=1, sel=0, ch=0, partial shadow discarded.
//    frame_data and frame_valid are not affected. abort wins over a simultaneous start.
//  ch wraps NCH-1 -> 0 only through PUBLISH. cont sampled in PUBLISH only.
//  Reset mid-scan: all outputs return to reset values immediately (asynchronous).
// STRUCTURE
//  Package mux_scan_pkg holds:
//   - scan_state_e enum (IDLE, SETUP, SETTLE, SAMPLE, PUBLISH)
//   - localparams NCH_DEF=16, SETTLE_DEF=2
//  Sub-module mux_scan_timer: loadable down-counter for SETTLE.
//   - inputs load, cnt_init[3:0]; output last
//  Frame output register and valid/ready logic stay inline in the top.
// TESTING
//  1. Reset, then start, with mux_in driven from channel pattern 0xA5C3 indexed by sel, en_n=0 gated,
//     ch_mask=0xFFFF -> frame_data=0xA5C3, frame_valid rises exactly 64 cycles after start.
//  2. Same pattern, ch_mask=0x00FF -> frame_data=0x00C3.
//     Channels 8..15 never see en_n=0. Latency = 8*4 + 8*2 = 48 cycles.
//  3. cont=1, frame_ready held 0 after the first frame -> FSM parks in PUBLISH, frame_data unchanged.
//     Raise ready for 1 cycle -> frame 2 loads in the same cycle, frame_valid stays 1.
//  4. abort pulse at channel 7 while a prior frame 0x1234 is pending -> IDLE, sel=0, en_n=1,
//     frame_data=0x1234, frame_valid still 1.
//  5. Assert rst_n=0 mid-SETTLE, asynchronously to clk -> en_n=1 and busy=0 before the next clock edge.
//  6. Assertion across all tests: sel is never observed changing while en_n=0.
//     INVERT=1 run of test 1 -> frame_data=0x5A3C.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
`default_nettype none
// mux_scan_pkg: shared state encoding and default sizing for the selector scan sequencer.
// Rev 1.0
package mux_scan_pkg;

  localparam int NCH_DEF    = 16;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SETTLE  = 3'd2,
    SAMPLE  = 3'd3,
    PUBLISH = 3'd4
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/mux_scan_sequencer_if.sv
`default_nettype none
// mux_scan_sequencer_if: selector drive/readback lines plus the frame valid/ready port.
// Rev 1.0
interface mux_scan_sequencer_if #(
  parameter int NCH  = 16,
  parameter int SELW = 4
);

  logic [SELW-1:0] sel;
  logic            en_n;
  logic            mux_in;
  logic [NCH-1:0]  frame_data;
  logic            frame_valid;
  logic            frame_ready;

  modport master (
    output sel, en_n, frame_data, frame_valid,
    input  mux_in, frame_ready
  );

  modport slave (
    input  sel, en_n, frame_data, frame_valid,
    output mux_in, frame_ready
  );

endinterface
`default_nettype wire

// File: rtl/mux_scan_sequencer_timer.sv
`default_nettype none
// mux_scan_timer: loadable down-counter; last flags the final cycle of a settle window.
// Rev 1.0
module mux_scan_timer (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       load,
  input  wire logic [3:0] cnt_init,
  output logic            last
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (load) begin
      r_cnt <= cnt_init;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign last = (r_cnt == 4'd1);

endmodule
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// mux_scan_sequencer: sweeps a 16:1 selector channel by channel and publishes each frame on valid/ready.
// Rev 1.0
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int SELW       = 4,
  parameter int SETTLE_CYC = SETTLE_DEF,
  parameter bit INVERT     = 1'b0
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           start,
  input  wire logic           cont,
  input  wire logic           abort,
  input  wire logic [NCH-1:0] ch_mask,
  output logic                busy,
  mux_scan_sequencer_if.master bus
);

  scan_state_e     r_state;
  logic [SELW-1:0] r_ch;
  logic [SELW-1:0] r_sel;
  logic            r_en_n;
  logic [NCH-1:0]  r_shadow;
  logic [NCH-1:0]  r_frame_data;
  logic            r_frame_valid;

  logic w_timer_last;
  logic w_out_free;
  logic w_last_ch;

  mux_scan_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (r_state == SETUP),
    .cnt_init (4'(SETTLE_CYC)),
    .last     (w_timer_last)
  );

  assign w_out_free = !r_frame_valid || bus.frame_ready;
  assign w_last_ch  = (r_ch == SELW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ch          <= '0;
      r_sel         <= '0;
      r_en_n        <= 1'b1;
      r_shadow      <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      // A consumer handshake retires the frame; a same-cycle load below overrides this.
      if (r_frame_valid && bus.frame_ready) begin
        r_frame_valid <= 1'b0;
      end

      if (abort) begin
        r_state <= IDLE;
        r_en_n  <= 1'b1;
        r_sel   <= '0;
        r_ch    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_shadow <= '0;
              r_ch     <= '0;
              r_sel    <= '0;
              r_state  <= SETUP;
            end
          end
          SETUP: begin
            if (!ch_mask[r_ch]) begin
              r_shadow[r_ch] <= 1'b0;
              r_state        <= SAMPLE;
            end else begin
              r_en_n  <= 1'b0;
              r_state <= SETTLE;
            end
          end
          SETTLE: begin
            if (w_timer_last) begin
              r_shadow[r_ch] <= bus.mux_in ^ INVERT;
              r_en_n         <= 1'b1;
              r_state        <= SAMPLE;
            end
          end
          SAMPLE: begin
            // With a free output register the frame loads straight from the last
            // sample, so PUBLISH only costs cycles under backpressure.
            if (w_last_ch) begin
              if (w_out_free) begin
                r_frame_data  <= r_shadow;
                r_frame_valid <= 1'b1;
                r_ch          <= '0;
                r_sel         <= '0;
                r_shadow      <= '0;
                r_state       <= cont ? SETUP : IDLE;
              end else begin
                r_state <= PUBLISH;
              end
            end else begin
              r_ch    <= r_ch + SELW'(1);
              r_sel   <= r_ch + SELW'(1);
              r_state <= SETUP;
            end
          end
          PUBLISH: begin
            if (w_out_free) begin
              r_frame_data  <= r_shadow;
              r_frame_valid <= 1'b1;
              r_ch          <= '0;
              r_sel         <= '0;
              r_shadow      <= '0;
              r_state       <= cont ? SETUP : IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_en_n  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign busy            = (r_state != IDLE);
  assign bus.sel         = r_sel;
  assign bus.en_n        = r_en_n;
  assign bus.frame_data  = r_frame_data;
  assign bus.frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// tb_mux_scan_sequencer: directed scans checked against a frame/latency model and literal values.
// Rev 1.0
module tb_mux_scan_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] ch_mask = 16'hFFFF;
  logic [15:0] pattern = 16'hA5C3;
  logic        busy1, busy2;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  mux_scan_sequencer_if #(.NCH(16), .SELW(4)) bus1 ();
  mux_scan_sequencer_if #(.NCH(16), .SELW(4)) bus2 ();

  assign bus1.mux_in      = bus1.en_n ? 1'b1 : pattern[bus1.sel];
  assign bus2.mux_in      = bus2.en_n ? 1'b1 : pattern[bus2.sel];
  assign bus1.frame_ready = ready;
  assign bus2.frame_ready = ready;

  mux_scan_sequencer #(.NCH(16), .SELW(4), .SETTLE_CYC(SETTLE), .INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
    .ch_mask(ch_mask), .busy(busy1), .bus(bus1)
  );

  mux_scan_sequencer #(.NCH(16), .SELW(4), .SETTLE_CYC(SETTLE), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
    .ch_mask(ch_mask), .busy(busy2), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_frame(input logic [15:0] pat, input logic [15:0] mask,
                                              input bit inv);
    logic [15:0] f = '0;
    for (int k = 0; k < 16; k++) f[k] = mask[k] ? (pat[k] ^ inv) : 1'b0;
    return f;
  endfunction

  function automatic int model_latency(input logic [15:0] mask);
    int n = 0;
    for (int k = 0; k < 16; k++) n += mask[k] ? (2 + SETTLE) : 2;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start and returns the number of edges after the start edge until frame_valid.
  task automatic scan_and_wait(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!bus1.frame_valid && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Handshake retires the oldest expected frame.
  always @(posedge clk) begin
    if (rst_n && bus1.frame_valid && bus1.frame_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  logic [3:0] prev_sel;
  logic       prev_en_n = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!prev_en_n && !bus1.en_n) check("sel_stable_while_enabled", 32'(bus1.sel), 32'(prev_sel));
      if (!bus1.en_n) check("enable_on_masked_channel", 32'(ch_mask[bus1.sel]), 32'd1);
      if (bus1.frame_valid) begin
        if (exp_q.size() == 0) check("frame_unexpected", 32'(bus1.frame_data), 32'hFFFF_FFFF);
        else check("frame_vs_model", 32'(bus1.frame_data), 32'(exp_q[0]));
      end
    end
    prev_sel  = bus1.sel;
    prev_en_n = bus1.en_n;
  end

  initial begin
    int lat;
    int guard;

    repeat (3) tick();
    check("reset_sel", 32'(bus1.sel), 32'd0);
    check("reset_en_n", 32'(bus1.en_n), 32'd1);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_frame_data", 32'(bus1.frame_data), 32'd0);
    check("reset_frame_valid", 32'(bus1.frame_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame, both polarities
    ch_mask = 16'hFFFF; pattern = 16'hA5C3;
    exp_q.push_back(model_frame(pattern, ch_mask, 1'b0));
    scan_and_wait(lat);
    check("t1_latency_model", 32'(lat), 32'(model_latency(ch_mask)));
    check("t1_latency_64", 32'(lat), 32'd64);
    check("t1_frame", 32'(bus1.frame_data), 32'hA5C3);
    check("t1_frame_inverted", 32'(bus2.frame_data), 32'h5A3C);
    check("t1_frame_inv_model", 32'(bus2.frame_data), 32'(model_frame(pattern, ch_mask, 1'b1)));
    check("t1_idle_after", 32'(busy1), 32'd0);
    ready = 1'b1; tick(); ready = 1'b0;
    check("t1_valid_cleared", 32'(bus1.frame_valid), 32'd0);

    // Upper half masked
    ch_mask = 16'h00FF;
    exp_q.push_back(model_frame(pattern, ch_mask, 1'b0));
    scan_and_wait(lat);
    check("t2_latency_model", 32'(lat), 32'(model_latency(ch_mask)));
    check("t2_latency_48", 32'(lat), 32'd48);
    check("t2_frame", 32'(bus1.frame_data), 32'h00C3);
    ready = 1'b1; tick(); ready = 1'b0;

    // Continuous mode under backpressure
    ch_mask = 16'hFFFF; cont = 1'b1;
    exp_q.push_back(model_frame(pattern, ch_mask, 1'b0));
    scan_and_wait(lat);
    check("t3_latency", 32'(lat), 32'd64);
    pattern = 16'h1234;
    exp_q.push_back(model_frame(pattern, ch_mask, 1'b0));
    repeat (100) tick();
    check("t3_parked_busy", 32'(busy1), 32'd1);
    check("t3_parked_valid", 32'(bus1.frame_valid), 32'd1);
    check("t3_parked_data", 32'(bus1.frame_data), 32'hA5C3);
    cont = 1'b0; ready = 1'b1; tick(); ready = 1'b0;
    check("t3_reload_valid", 32'(bus1.frame_valid), 32'd1);
    check("t3_reload_data", 32'(bus1.frame_data), 32'h1234);
    check("t3_idle_after", 32'(busy1), 32'd0);

    // Abort with a frame pending
    pattern = 16'hA5C3;
    exp_q.push_back(model_frame(pattern, ch_mask, 1'b0));
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!(bus1.sel == 4'd7 && !bus1.en_n) && guard < 200) begin
      tick();
      guard++;
    end
    check("t4_reached_ch7", 32'(guard < 200), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    void'(exp_q.pop_back());
    check("t4_busy", 32'(busy1), 32'd0);
    check("t4_sel", 32'(bus1.sel), 32'd0);
    check("t4_en_n", 32'(bus1.en_n), 32'd1);
    check("t4_frame_data", 32'(bus1.frame_data), 32'h1234);
    check("t4_frame_valid", 32'(bus1.frame_valid), 32'd1);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("t4_abort_beats_start", 32'(busy1), 32'd0);
    ready = 1'b1; tick(); ready = 1'b0;
    check("t4_drained", 32'(bus1.frame_valid), 32'd0);

    // Asynchronous reset in the middle of a settle window
    exp_q.push_back(model_frame(pattern, ch_mask, 1'b0));
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (bus1.en_n && guard < 50) begin
      tick();
      guard++;
    end
    check("t5_in_settle", 32'(bus1.en_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_en_n", 32'(bus1.en_n), 32'd1);
    check("t5_async_busy", 32'(busy1), 32'd0);
    check("t5_async_sel", 32'(bus1.sel), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("t5_stays_idle", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
